// File: rtl/av2_recon_mem_arbiter_if.sv
// Bus between the three reconstruction-memory requesters, the arbiter and the
// single-port frame SRAM.
interface av2_recon_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10
);
  logic [2:0]          req_valid;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [11:0]         req_len;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          req_grant;
  logic [2:0]          beat_ack;
  logic [2:0]          rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  logic [1:0]          grant_id;

  // Arbiter side: consumes requests and read data, drives grants and SRAM controls
  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, mem_rdata,
    output req_grant, beat_ack, rd_valid, rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

  // Requester/memory side as seen from the environment
  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, mem_rdata,
    input  req_grant, beat_ack, rd_valid, rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );
endinterface

// File: rtl/av2_recon_mem_arbiter.sv
// Round-robin burst arbiter for the reconstruction frame SRAM. Three
// requesters (recon store, neighbour fetch, output drain) share one
// registered single-port memory; a winning burst runs to completion.
module av2_recon_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  av2_recon_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_d;
  logic [1:0]        last, last_d, grant_id_d;
  logic              lat_we, lat_we_d;
  logic [ADDR_W-1:0] base, base_d;
  logic [3:0]        len, len_d;
  logic [4:0]        cnt, cnt_d;
  logic [2:0]        req_grant_d, beat_ack_d;
  logic              mem_en_d, mem_we_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              rd_pend;
  logic [1:0]        rd_id;

  logic [ADDR_W-1:0] addr_a  [3];
  logic [DATA_W-1:0] wdata_a [3];
  logic [3:0]        len_a   [3];
  logic [1:0]        cand1, cand2, winner;

  for (genvar i = 0; i < 3; i++) begin : g_split
    assign addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    assign len_a[i]   = bus.req_len[i*4 +: 4];
  end

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Search order starts just after the previous winner and ends on it
  assign cand1  = rr_next(last);
  assign cand2  = rr_next(cand1);
  assign winner = bus.req_valid[cand1] ? cand1 :
                  bus.req_valid[cand2] ? cand2 : last;

  // Next-state logic: pick a winner in IDLE, walk the burst beats in BURST
  always_comb begin
    state_d     = state;
    last_d      = last;
    grant_id_d  = bus.grant_id;
    lat_we_d    = lat_we;
    base_d      = base;
    len_d       = len;
    cnt_d       = cnt;
    busy_d      = bus.busy;
    req_grant_d = 3'b000;
    beat_ack_d  = 3'b000;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d             = BURST;
          last_d              = winner;
          grant_id_d          = winner;
          lat_we_d            = bus.req_we[winner];
          base_d              = addr_a[winner];
          len_d               = len_a[winner];
          cnt_d               = 5'd1;
          busy_d              = 1'b1;
          req_grant_d[winner] = 1'b1;
          beat_ack_d[winner]  = 1'b1;
          mem_en_d            = 1'b1;
          mem_we_d            = bus.req_we[winner];
          mem_addr_d          = addr_a[winner];
          mem_wdata_d         = wdata_a[winner];
        end
      end
      BURST: begin
        if (cnt == {1'b0, len} + 5'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 5'd0;
        end else begin
          cnt_d                    = cnt + 5'd1;
          beat_ack_d[bus.grant_id] = 1'b1;
          mem_en_d                 = 1'b1;
          mem_we_d                 = lat_we;
          mem_addr_d               = base + ADDR_W'(cnt);
          mem_wdata_d              = wdata_a[bus.grant_id];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, plus the two-stage read-return pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 2'd2;
      lat_we        <= 1'b0;
      base          <= '0;
      len           <= '0;
      cnt           <= '0;
      rd_pend       <= 1'b0;
      rd_id         <= 2'd0;
      bus.grant_id  <= 2'd0;
      bus.busy      <= 1'b0;
      bus.req_grant <= 3'b000;
      bus.beat_ack  <= 3'b000;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rd_valid  <= 3'b000;
      bus.rd_data   <= '0;
    end else begin
      state         <= state_d;
      last          <= last_d;
      lat_we        <= lat_we_d;
      base          <= base_d;
      len           <= len_d;
      cnt           <= cnt_d;
      bus.grant_id  <= grant_id_d;
      bus.busy      <= busy_d;
      bus.req_grant <= req_grant_d;
      bus.beat_ack  <= beat_ack_d;
      bus.mem_en    <= mem_en_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
      rd_pend       <= bus.mem_en & ~bus.mem_we;
      rd_id         <= bus.grant_id;
      bus.rd_valid  <= rd_pend ? (3'b001 << rd_id) : 3'b000;
      if (rd_pend) bus.rd_data <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_av2_recon_mem_arbiter.sv
// Directed bench for the reconstruction memory arbiter: round-robin order,
// long write bursts, read return timing, address wrap, reset behaviour.
module tb_av2_recon_mem_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] mem_q = '0;
  int checks = 0;
  int fails = 0;

  logic [ADDR_W-1:0] wrap_addr [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
  logic [DATA_W-1:0] wrap_data [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

  av2_recon_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  av2_recon_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // SRAM model: read data is the low ten address bits, one cycle after mem_en
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) mem_q <= bus.mem_addr[9:0];
  end
  assign bus.mem_rdata = mem_q;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic v, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                               input logic [DATA_W-1:0] wd);
    bus.req_valid[id] = v;
    bus.req_we[id] = we;
    bus.req_addr[id*ADDR_W +: ADDR_W] = addr;
    bus.req_len[id*4 +: 4] = len;
    bus.req_wdata[id*DATA_W +: DATA_W] = wd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " mem_en"}, bus.mem_en, 0);
    checkOutput({tag, " mem_we"}, bus.mem_we, 0);
    checkOutput({tag, " mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, " mem_wdata"}, bus.mem_wdata, 0);
    checkOutput({tag, " busy"}, bus.busy, 0);
    checkOutput({tag, " grant_id"}, bus.grant_id, 0);
    checkOutput({tag, " req_grant"}, bus.req_grant, 0);
    checkOutput({tag, " beat_ack"}, bus.beat_ack, 0);
    checkOutput({tag, " rd_valid"}, bus.rd_valid, 0);
    checkOutput({tag, " rd_data"}, bus.rd_data, 0);
  endtask

  initial begin
    int nw, na, nb, ng, wd;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_wdata = '0;

    $display("[TB] reset state");
    tick();
    tick();
    checkIdle("reset");

    $display("[TB] round-robin with all requesters held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0, ADDR_W'(16 * i), 4'd0, '0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("rr grant %0d", k), bus.req_grant,
                  (k % 2) ? 0 : (3'b001 << ((k / 2) % 3)));
      checkOutput($sformatf("rr mem_en %0d", k), bus.mem_en, (k % 2) ? 0 : 1);
      if (k % 2 == 0) checkOutput($sformatf("rr grant_id %0d", k), bus.grant_id, (k / 2) % 3);
    end
    bus.req_valid = 3'b000;
    tick();
    checkOutput("idle mem_en", bus.mem_en, 0);
    checkOutput("idle mem_addr", bus.mem_addr, 0);
    checkOutput("idle busy", bus.busy, 0);
    tick();
    tick();
    tick();

    $display("[TB] 16-beat write from requester 0");
    nw = 0; na = 0; nb = 0; ng = 0; wd = 0;
    applyStimulus(0, 1'b1, 1'b1, 14'h0100, 4'd15, 10'd0);
    for (int k = 0; k < 22; k++) begin
      tick();
      if (bus.req_grant[0]) begin ng++; bus.req_valid[0] = 1'b0; end
      if (bus.busy) nb++;
      if (bus.mem_en && bus.mem_we) begin
        checkOutput($sformatf("wr addr %0d", nw), bus.mem_addr, 32'h100 + nw);
        checkOutput($sformatf("wr data %0d", nw), bus.mem_wdata, nw);
        nw++;
      end
      if (bus.beat_ack[0]) begin
        na++;
        wd++;
        bus.req_wdata[0 +: DATA_W] = DATA_W'(wd);
      end
    end
    checkOutput("wr beats", nw, 16);
    checkOutput("wr beat_acks", na, 16);
    checkOutput("wr busy cycles", nb, 16);
    checkOutput("wr grants", ng, 1);

    $display("[TB] 4-beat read from requester 2");
    applyStimulus(2, 1'b1, 1'b0, 14'h0040, 4'd3, '0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("rd grant", bus.req_grant, 3'b100);
        bus.req_valid[2] = 1'b0;
      end
      checkOutput($sformatf("rd mem_en %0d", k), bus.mem_en, (k <= 4) ? 1 : 0);
      checkOutput($sformatf("rd rd_valid %0d", k), bus.rd_valid,
                  (k >= 3 && k <= 6) ? 3'b100 : 3'b000);
      if (k >= 3 && k <= 6) checkOutput($sformatf("rd rd_data %0d", k), bus.rd_data, 32'h40 + k - 3);
    end

    $display("[TB] wrapping read from requester 1 overlapped by a new burst");
    applyStimulus(1, 1'b1, 1'b0, 14'h3FFE, 4'd3, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("wrap grant", bus.req_grant, 3'b010);
        bus.req_valid[1] = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 14'h0123, 4'd0, 10'h155);
      end
      if (k <= 4) checkOutput($sformatf("wrap addr %0d", k), bus.mem_addr, wrap_addr[k-1]);
      checkOutput($sformatf("wrap mem_en %0d", k), bus.mem_en, (k <= 4 || k == 6) ? 1 : 0);
      checkOutput($sformatf("wrap rd_valid %0d", k), bus.rd_valid,
                  (k >= 3 && k <= 6) ? 3'b010 : 3'b000);
      if (k >= 3 && k <= 6) checkOutput($sformatf("wrap rd_data %0d", k), bus.rd_data, wrap_data[k-3]);
      if (k == 6) begin
        checkOutput("next grant", bus.req_grant, 3'b001);
        checkOutput("next addr", bus.mem_addr, 14'h0123);
        checkOutput("next we", bus.mem_we, 1);
        checkOutput("next wdata", bus.mem_wdata, 10'h155);
        bus.req_valid[0] = 1'b0;
      end
    end

    $display("[TB] reset in the middle of a write burst");
    applyStimulus(0, 1'b1, 1'b1, 14'h0200, 4'd15, 10'h2AA);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) bus.req_valid[0] = 1'b0;
    end
    checkOutput("beat5 mem_en", bus.mem_en, 1);
    checkOutput("beat5 addr", bus.mem_addr, 14'h0205);
    rst_n = 1'b0;
    #1;
    checkIdle("async reset");
    tick();
    tick();
    applyStimulus(1, 1'b1, 1'b0, 14'h0777, 4'd0, '0);
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset grant", bus.req_grant, 3'b010);
    checkOutput("post-reset grant_id", bus.grant_id, 1);
    checkOutput("post-reset addr", bus.mem_addr, 14'h0777);
    bus.req_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    tick();

    $display("[TB] reset with read data in flight");
    applyStimulus(2, 1'b1, 1'b0, 14'h0050, 4'd3, '0);
    tick();
    checkOutput("flight grant", bus.req_grant, 3'b100);
    bus.req_valid[2] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("flight rd_valid %0d", k), bus.rd_valid, 0);
      checkOutput($sformatf("flight mem_en %0d", k), bus.mem_en, 0);
    end

    $display("[TB] requester 0 drops valid after grant");
    nw = 0; ng = 0;
    applyStimulus(0, 1'b1, 1'b1, 14'h0300, 4'd7, 10'h011);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.req_grant != 3'b000) begin ng++; bus.req_valid[0] = 1'b0; end
      if (bus.mem_en) nw++;
    end
    checkOutput("drop beats", nw, 8);
    checkOutput("drop grants", ng, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/av2_recon_mem_arbiter.md
AV2_RECON_MEM_ARBITER -- requirements
Module: av2_recon_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word address width of the reconstruction frame memory (128x128 pixels).
REQ-002 SHALL have parameter DATA_W, default 10, meaning pixel width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 3, burst request per requester (0 = recon store, 1 = neighbour fetch, 2 = output drain).
REQ-006 SHALL have port req_we, input, 3, per-requester burst direction (1 = write).
REQ-007 SHALL have port req_addr, input, 3*ADDR_W, burst base address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_len, input, 12, burst length minus 1 (4 bits per requester, 0 -> 1 beat, 15 -> 16 beats).
REQ-009 SHALL have port req_wdata, input, 3*DATA_W, per-requester current write beat data.
REQ-010 SHALL have port req_grant, output, 3, one-cycle pulse when that requester's burst is accepted.
REQ-011 SHALL have port beat_ack, output, 3, one-cycle pulse per issued beat of the owning requester.
REQ-012 SHALL have port rd_valid, output, 3, read data valid for that requester; rd_data, output, DATA_W, shared read data.
REQ-013 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W): registered single-port SRAM controls; mem_rdata, input, DATA_W, returned the cycle after mem_en.
REQ-014 SHALL have ports busy, output, 1 (burst in progress) and grant_id, output, 2 (current/last owner).

Function
REQ-015 SHALL implement two states: IDLE and BURST.
REQ-016 In IDLE with any req_valid set, SHALL select a winner round-robin: search order last+1, last+2, last (mod 3), where last is the previous winner.
REQ-017 At the selecting edge SHALL latch winner id, we, base addr, len; pulse req_grant[winner]; set last = winner, grant_id = winner, busy = 1; issue beat 0; enter BURST.
REQ-018 Beat k SHALL drive mem_en = 1, mem_we = latched we, mem_addr = (base + k) mod 2^ADDR_W, mem_wdata = winner's req_wdata sampled at that edge.
REQ-019 beat_ack[winner] SHALL be high the cycle after each beat edge; requester presents next wdata in that cycle (beat 0 data presented with req_valid).
REQ-020 Exactly len+1 consecutive beats SHALL issue; at the edge after the last beat mem_en = 0, busy = 0, state = IDLE.
REQ-021 Arbitration SHALL occur only in IDLE; consecutive bursts SHALL be separated by exactly one mem_en = 0 cycle.
REQ-022 For read bursts, rd_data SHALL register mem_rdata the cycle after each mem_en cycle, with rd_valid[owner] high the following cycle (2 cycles after the beat edge), in beat order.
REQ-023 req_valid/addr/len/we changes after req_grant SHALL be ignored until the burst ends; deasserting req_valid mid-burst SHALL NOT truncate the burst.
REQ-024 A requester still asserting req_valid after its burst SHALL be treated as a new request, subject to round-robin.
REQ-025 Address wrap: base 0x3FFE, len 3 SHALL issue 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-026 No req_valid in IDLE SHALL keep all mem_* outputs 0 and last unchanged.
REQ-027 rd_valid for reads of the final beat SHALL still be delivered even if a new burst has started.

Reset
REQ-028 rst_n low SHALL immediately force state = IDLE, last = 2 (requester 0 first), beat counter 0, and all outputs (req_grant, beat_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id) to 0.
REQ-029 Reset mid-burst SHALL abandon the burst; pending read data SHALL NOT produce rd_valid after reset release.

Verification
REQ-030 After reset, req_valid = 3'b111 all len 0, held -> grants in order 0, 1, 2, 0; mem_en pattern 1,0,1,0...
REQ-031 Requester 0 write, base 0x0100, len 15, wdata incrementing on beat_ack -> 16 writes to 0x0100..0x010F, data 0..15, 16 beat_ack pulses, busy 16 cycles.
REQ-032 Requester 2 read, base 0x0040, len 3, mem_rdata = addr[9:0] -> rd_valid[2] 4 consecutive cycles, rd_data 0x040..0x043, first 2 cycles after beat 0.
REQ-033 Requester 1 read base 0x3FFE len 3 -> mem_addr 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-034 rst_n asserted after beat 5 of a 16-beat write -> all outputs 0 same cycle; after release, req_valid = 3'b010 grants requester 1 first.
REQ-035 Requester 0 drops req_valid after grant, len 7 -> 8 beats still issued, no second grant.
